// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default geometry,
// opcode map, instruction field layout and the fetch FSM state type.
package instruction_fetch_unit_pkg;

    // Default geometry of the fetch path.
    localparam int unsigned ADDR_WIDTH_DEF  = 32'd16;
    localparam int unsigned INSN_WIDTH_DEF  = 32'd28;
    localparam int unsigned DELAY_WIDTH_DEF = 32'd24;
    localparam logic [15:0] RESET_PC_DEF    = 16'h0000;

    // Opcode map. The opcode occupies bits [27:20]. A NOP carries a 24-bit
    // delay literal in bits [23:0], so only the top nibble [27:24]
    // identifies it. The whole 8'h0x opcode row is therefore reserved for NOP.
    typedef enum logic [7:0] {
        OPC_NOP  = 8'h00,
        OPC_STO  = 8'h10,
        OPC_ADD  = 8'h20,
        OPC_JMP  = 8'h30,
        OPC_BLE  = 8'h40,
        OPC_SMUL = 8'h50
    } opcode_e;

    // Top opcode nibble shared by every NOP encoding.
    localparam logic [3:0] NOP_CLASS = 4'h0;

    // Fetch FSM states.
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DELAY = 1'b1
    } fetch_state_e;

    // True when the top opcode nibble marks the instruction as a NOP.
    function automatic logic is_nop(input logic [3:0] opc_class);
        return (opc_class == NOP_CLASS);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_delay_counter.sv
// NOP delay counter: loadable down-counter with clear, decrement enable,
// zero detect and a "last bubble" flag (count == 1).
module fetch_delay_counter #(
    parameter int unsigned WIDTH = 32'd24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero,
    output logic             last
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_s;

    // Next count: clear beats load beats decrement; a zero count never wraps.
    always_comb begin
        count_s = count_r;
        if (clear) begin
            count_s = {WIDTH{1'b0}};
        end else if (load) begin
            count_s = load_value;
        end else if (en && (count_r != {WIDTH{1'b0}})) begin
            count_s = count_r - CNT_ONE;
        end else begin
            count_s = count_r;
        end
    end

    // Counter register with asynchronous reset to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
        end else begin
            count_r <= count_s;
        end
    end

    assign zero = (count_r == {WIDTH{1'b0}});
    assign last = (count_r == CNT_ONE);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the combinational ROM address, registers
// the returned instruction for decode, and handles branch redirects, stalls
// and NOP-literal bubble insertion.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned           INSN_WIDTH  = INSN_WIDTH_DEF,
    parameter int unsigned           DELAY_WIDTH = DELAY_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = RESET_PC_DEF
) (
    input  logic                  Clock,
    input  logic                  Reset,
    output logic [ADDR_WIDTH-1:0] oAddress,
    input  logic [INSN_WIDTH-1:0] iInstruction,
    input  logic                  iStall,
    input  logic                  iBranchTaken,
    input  logic [ADDR_WIDTH-1:0] iBranchTarget,
    output logic [INSN_WIDTH-1:0] oInstruction,
    output logic                  oValid,
    output logic [ADDR_WIDTH-1:0] oPC
);

    localparam logic [ADDR_WIDTH-1:0] PC_ONE     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    // NOP with a zero literal: what decode sees before the first fetch.
    localparam logic [INSN_WIDTH-1:0] RESET_INSN = {NOP_CLASS, {DELAY_WIDTH{1'b0}}};

    fetch_state_e          state_r, state_s;
    logic [ADDR_WIDTH-1:0] pc_r, pc_s;
    logic [INSN_WIDTH-1:0] insn_r, insn_s;
    logic                  valid_r, valid_s;
    logic [ADDR_WIDTH-1:0] fpc_r, fpc_s;

    logic                   cnt_clear_s;
    logic                   cnt_load_s;
    logic                   cnt_dec_s;
    logic                   cnt_zero_s;
    logic                   cnt_last_s;
    logic [DELAY_WIDTH-1:0] lit_s;
    logic                   nop_s;

    assign lit_s = iInstruction[DELAY_WIDTH-1:0];
    assign nop_s = is_nop(iInstruction[INSN_WIDTH-1:DELAY_WIDTH]);

    fetch_delay_counter #(
        .WIDTH (DELAY_WIDTH)
    ) u_delay (
        .clk        (Clock),
        .rst        (Reset),
        .clear      (cnt_clear_s),
        .load       (cnt_load_s),
        .en         (cnt_dec_s),
        .load_value (lit_s),
        .zero       (cnt_zero_s),
        .last       (cnt_last_s)
    );

    // Next-state and datapath: branch > stall > DELAY/RUN; defaults hold all state.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        insn_s      = insn_r;
        valid_s     = valid_r;
        fpc_s       = fpc_r;
        cnt_clear_s = 1'b0;
        cnt_load_s  = 1'b0;
        cnt_dec_s   = 1'b0;
        if (iBranchTaken) begin
            // Redirect drops the wrong-path fetch and any pending bubbles.
            pc_s        = iBranchTarget;
            valid_s     = 1'b0;
            cnt_clear_s = 1'b1;
            state_s     = ST_RUN;
        end else if (iStall) begin
            // Execute is busy: everything, including the counter, holds.
            state_s = state_r;
        end else begin
            case (state_r)
                ST_RUN: begin
                    insn_s  = iInstruction;
                    fpc_s   = pc_r;
                    valid_s = 1'b1;
                    pc_s    = pc_r + PC_ONE;
                    if (nop_s && (lit_s != {DELAY_WIDTH{1'b0}})) begin
                        cnt_load_s = 1'b1;
                        state_s    = ST_DELAY;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_DELAY: begin
                    valid_s   = 1'b0;
                    cnt_dec_s = 1'b1;
                    // Zero here is unreachable; treat it as "delay done".
                    if (cnt_last_s || cnt_zero_s) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_DELAY;
                    end
                end
                default: begin
                    state_s     = ST_RUN;
                    valid_s     = 1'b0;
                    cnt_clear_s = 1'b1;
                end
            endcase
        end
    end

    // State, PC and decode-facing output registers with asynchronous reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_RUN;
            pc_r    <= RESET_PC;
            insn_r  <= RESET_INSN;
            valid_r <= 1'b0;
            fpc_r   <= RESET_PC;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            insn_r  <= insn_s;
            valid_r <= valid_s;
            fpc_r   <= fpc_s;
        end
    end

    assign oAddress     = pc_r;
    assign oInstruction = insn_r;
    assign oValid       = valid_r;
    assign oPC          = fpc_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a ROM model and a
// scoreboard of expected (pc, instruction) pairs popped on each new fetch.
module tb_instruction_fetch_unit;

    typedef struct packed {
        logic [15:0] pc;
        logic [27:0] insn;
    } exp_t;

    logic        Clock;
    logic        Reset;
    logic [15:0] oAddress;
    logic [27:0] iInstruction;
    logic        iStall;
    logic        iBranchTaken;
    logic [15:0] iBranchTarget;
    logic [27:0] oInstruction;
    logic        oValid;
    logic [15:0] oPC;

    logic [27:0] rom [0:65535];
    exp_t        sb [$];
    int          checks;
    int          failures;

    instruction_fetch_unit dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .oAddress      (oAddress),
        .iInstruction  (iInstruction),
        .iStall        (iStall),
        .iBranchTaken  (iBranchTaken),
        .iBranchTarget (iBranchTarget),
        .oInstruction  (oInstruction),
        .oValid        (oValid),
        .oPC           (oPC)
    );

    assign iInstruction = rom[oAddress];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] pc);
        exp_t e;
        e.pc   = pc;
        e.insn = rom[pc];
        sb.push_back(e);
    endtask

    // One clock; a valid output produced by an unstalled, unbranched edge is a
    // new fetch and must match the head of the scoreboard.
    task automatic step();
        logic adv;
        exp_t e;
        adv = !iStall && !iBranchTaken;
        @(posedge Clock);
        #1;
        if (oValid && adv) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL sb_underflow observed=empty expected=pending_entry pc=%0h", oPC);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_insn", 32'(oInstruction), 32'(e.insn));
                chk("sb_pc", 32'(oPC), 32'(e.pc));
            end
        end
    endtask

    task automatic release_reset();
        @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(oValid), 32'd0);
        chk({tag, "_insn"}, 32'(oInstruction), 32'h0000000);
        chk({tag, "_pc"}, 32'(oPC), 32'h0000);
        chk({tag, "_addr"}, 32'(oAddress), 32'h0000);
    endtask

    initial begin
        logic saw_valid;
        checks        = 0;
        failures      = 0;
        Reset         = 1'b1;
        iStall        = 1'b0;
        iBranchTaken  = 1'b0;
        iBranchTarget = 16'h0000;
        for (int i = 0; i < 65536; i++) rom[i] = 28'h1000000 | 28'(i);

        // Reset state and plain sequential fetch.
        #1;
        chk_reset_outputs("reset");
        rom[0] = 28'h1000001; rom[1] = 28'h1000002;
        rom[2] = 28'h1000003; rom[3] = 28'h2000004;
        push(16'd0); push(16'd1); push(16'd2);
        release_reset();
        chk("seq_addr0", 32'(oAddress), 32'd0);
        chk("seq_valid0", 32'(oValid), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("seq_addr", 32'(oAddress), 32'(i));
            chk("seq_valid", 32'(oValid), 32'd1);
        end

        // NOP with literal 4: exactly four bubbles, address held at 1.
        Reset = 1'b1;
        #1;
        sb.delete();
        chk_reset_outputs("reset2");
        rom[0] = 28'h0000004; rom[1] = 28'h2000011;
        push(16'd0); push(16'd1);
        release_reset();
        step();
        chk("nop_valid", 32'(oValid), 32'd1);
        chk("nop_addr", 32'(oAddress), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bubble_valid", 32'(oValid), 32'd0);
            chk("bubble_addr", 32'(oAddress), 32'd1);
        end
        step();
        chk("post_nop_valid", 32'(oValid), 32'd1);
        chk("post_nop_addr", 32'(oAddress), 32'd2);

        // Three-cycle stall while SMUL at address 5 is presented.
        Reset = 1'b1;
        #1;
        sb.delete();
        for (int i = 0; i < 5; i++) rom[i] = 28'h1000000 | 28'(i);
        rom[5] = 28'h5012345; rom[6] = 28'h1000066;
        for (int i = 0; i < 7; i++) push(16'(i));
        release_reset();
        for (int i = 0; i < 6; i++) step();
        chk("smul_insn", 32'(oInstruction), 32'h5012345);
        chk("smul_addr", 32'(oAddress), 32'd6);
        iStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_insn", 32'(oInstruction), 32'h5012345);
            chk("stall_pc", 32'(oPC), 32'd5);
            chk("stall_addr", 32'(oAddress), 32'd6);
            chk("stall_valid", 32'(oValid), 32'd1);
        end
        iStall = 1'b0;
        step();
        chk("unstall_pc", 32'(oPC), 32'd6);
        chk("unstall_addr", 32'(oAddress), 32'd7);

        // Branch to 2 from PC 15 with stall also high: branch wins.
        Reset = 1'b1;
        #1;
        sb.delete();
        for (int i = 0; i < 16; i++) rom[i] = 28'h1000100 | 28'(i);
        rom[2] = 28'h2000222;
        for (int i = 0; i < 15; i++) push(16'(i));
        release_reset();
        for (int i = 0; i < 15; i++) step();
        chk("pre_branch_addr", 32'(oAddress), 32'd15);
        iBranchTaken  = 1'b1;
        iBranchTarget = 16'd2;
        iStall        = 1'b1;
        step();
        chk("branch_bubble", 32'(oValid), 32'd0);
        chk("branch_addr", 32'(oAddress), 32'd2);
        iBranchTaken = 1'b0;
        iStall       = 1'b0;
        push(16'd2);
        step();
        chk("target_valid", 32'(oValid), 32'd1);
        chk("target_insn", 32'(oInstruction), 32'h2000222);
        chk("target_addr", 32'(oAddress), 32'd3);

        // Branch to 16'hFFFF, then wrap to 0 without a gap.
        rom[16'hFFFF] = 28'h3000FFF;
        iBranchTaken  = 1'b1;
        iBranchTarget = 16'hFFFF;
        step();
        chk("wrap_bubble", 32'(oValid), 32'd0);
        chk("wrap_addr_top", 32'(oAddress), 32'hFFFF);
        iBranchTaken = 1'b0;
        push(16'hFFFF); push(16'h0000);
        step();
        chk("wrap_valid_top", 32'(oValid), 32'd1);
        chk("wrap_addr_zero", 32'(oAddress), 32'h0000);
        step();
        chk("wrap_valid_zero", 32'(oValid), 32'd1);
        chk("wrap_addr_one", 32'(oAddress), 32'h0001);

        // Asynchronous reset in the middle of a 4000-cycle NOP delay.
        Reset = 1'b1;
        #1;
        sb.delete();
        rom[0] = 28'h0000FA0; rom[1] = 28'h2000011;
        push(16'd0);
        release_reset();
        step();
        chk("long_nop_valid", 32'(oValid), 32'd1);
        saw_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (oValid) saw_valid = 1'b1;
        end
        chk("long_bubbles", 32'(saw_valid), 32'd0);
        chk("long_addr_held", 32'(oAddress), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        sb.delete();
        rom[0] = 28'h0000000; rom[1] = 28'h2000011;
        push(16'd0); push(16'd1);
        release_reset();
        chk("restart_addr", 32'(oAddress), 32'd0);
        step();
        chk("restart_valid0", 32'(oValid), 32'd1);
        chk("restart_addr1", 32'(oAddress), 32'd1);
        step();
        chk("restart_valid1", 32'(oValid), 32'd1);
        chk("restart_addr2", 32'(oAddress), 32'd2);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
